// File: rtl/axicb_prio_arbiter.sv
// Priority / round-robin arbiter for the axicb crossbar slave ports.
// The grant is registered and held until done or abort, and aging counters promote starved requesters.
module axicb_prio_arbiter #(
    parameter int unsigned REQ_NB  = 8,
    parameter int unsigned PRIO_NB = 4,
    parameter logic [REQ_NB*((PRIO_NB > 1) ? $clog2(PRIO_NB) : 1)-1:0] REQ_PRIORITY = '0,
    parameter int unsigned AGE_MAX = 15
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      srst,
    input  logic                      en,
    input  logic [REQ_NB-1:0]         req,
    input  logic                      done,
    output logic [REQ_NB-1:0]         grant,
    output logic [$clog2(REQ_NB)-1:0] grant_id,
    output logic                      busy,
    output logic [REQ_NB-1:0]         aged
);

    localparam int unsigned PRIO_W = (PRIO_NB > 1) ? $clog2(PRIO_NB) : 1;
    localparam int unsigned LVL_NB = PRIO_NB + 1;
    localparam int unsigned LVL_W  = $clog2(LVL_NB);
    localparam int unsigned ID_W   = $clog2(REQ_NB);
    localparam int unsigned AGE_W  = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Reject static priorities outside 0..PRIO_NB-1 at elaboration
    for (genvar gi = 0; gi < REQ_NB; gi++) begin : g_prio_chk
        if (32'(REQ_PRIORITY[gi*PRIO_W +: PRIO_W]) >= PRIO_NB) begin : g_bad
            $fatal(1, "axicb_prio_arbiter: REQ_PRIORITY field %0d out of range", gi);
        end
    end

    state_t            state;
    logic [ID_W-1:0]   ptr     [LVL_NB];
    logic [AGE_W-1:0]  age     [REQ_NB];
    logic [AGE_W-1:0]  age_nxt [REQ_NB];
    logic [REQ_NB-1:0] aged_nxt;

    logic [LVL_W-1:0]  eff_lvl [REQ_NB];
    logic [LVL_W-1:0]  top_lvl;
    logic [REQ_NB-1:0] cand;
    logic [ID_W-1:0]   ptr_sel;
    logic [ID_W-1:0]   scan_idx;
    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    logic              release_c;
    logic              others_c;

    // Effective levels and the candidate set at the highest requesting level
    always_comb begin
        top_lvl = '0;
        cand    = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            eff_lvl[i] = aged[i] ? LVL_W'(PRIO_NB)
                                 : LVL_W'(REQ_PRIORITY[i*PRIO_W +: PRIO_W]);
            if (req[i] && (eff_lvl[i] > top_lvl)) begin
                top_lvl = eff_lvl[i];
            end
        end
        for (int i = 0; i < REQ_NB; i++) begin
            cand[i] = req[i] && (eff_lvl[i] == top_lvl);
        end
    end

    // Round-robin pick: descending scan so the nearest candidate after ptr wins
    always_comb begin
        ptr_sel  = ptr[top_lvl];
        scan_idx = '0;
        win_vld  = 1'b0;
        win_id   = '0;
        for (int unsigned k = REQ_NB; k >= 1; k--) begin
            scan_idx = ID_W'((32'(ptr_sel) + k) % REQ_NB);
            if (cand[scan_idx]) begin
                win_vld = 1'b1;
                win_id  = scan_idx;
            end
        end
    end

    always_comb begin
        release_c = done || !req[grant_id];
        others_c  = |(req & ~grant);
    end

    // Aging: count blocked cycles, clear on idle request or while holding the grant
    always_comb begin
        aged_nxt = aged;
        for (int i = 0; i < REQ_NB; i++) begin
            age_nxt[i] = age[i];
            if (en) begin
                if (!req[i] || grant[i]) begin
                    age_nxt[i] = '0;
                end else if (32'(age[i]) < AGE_MAX) begin
                    age_nxt[i] = age[i] + AGE_W'(1);
                end
                aged_nxt[i] = (AGE_MAX != 0) && (32'(age_nxt[i]) == AGE_MAX);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            aged     <= '0;
            for (int l = 0; l < LVL_NB; l++) ptr[l] <= ID_W'(REQ_NB - 1);
            for (int i = 0; i < REQ_NB; i++) age[i] <= '0;
        end else if (srst) begin
            state    <= S_IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            aged     <= '0;
            for (int l = 0; l < LVL_NB; l++) ptr[l] <= ID_W'(REQ_NB - 1);
            for (int i = 0; i < REQ_NB; i++) age[i] <= '0;
        end else begin
            aged <= aged_nxt;
            for (int i = 0; i < REQ_NB; i++) age[i] <= age_nxt[i];

            case (state)
                S_IDLE: begin
                    if (en && win_vld) begin
                        state         <= S_BUSY;
                        busy          <= 1'b1;
                        grant         <= REQ_NB'(1) << win_id;
                        grant_id      <= win_id;
                        ptr[top_lvl]  <= win_id;
                    end
                end
                S_BUSY: begin
                    if (release_c) begin
                        if (en && others_c && win_vld) begin
                            grant        <= REQ_NB'(1) << win_id;
                            grant_id     <= win_id;
                            ptr[top_lvl] <= win_id;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            grant <= '0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axicb_prio_arbiter.sv
// Directed bench for axicb_prio_arbiter: a fair, a strict-priority and an aging instance share one stimulus.
module tb_axicb_prio_arbiter;

    localparam int unsigned N  = 4;
    localparam int          NV = 22;

    logic         clk;
    logic         aresetn;
    logic         srst;
    logic         en;
    logic         done;
    logic [N-1:0] req;

    logic [N-1:0] grant_f, grant_s, grant_a;
    logic [N-1:0] aged_f, aged_s, aged_a;
    logic [1:0]   id_f, id_s, id_a;
    logic         busy_f, busy_s, busy_a;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         en;
        logic [N-1:0] req;
        logic         done;
        logic [N-1:0] grant;
        logic [1:0]   id;
        logic         busy;
    } vec_t;

    vec_t tbl [NV];

    axicb_prio_arbiter #(.REQ_NB(4), .PRIO_NB(4), .REQ_PRIORITY(8'h00), .AGE_MAX(0)) dut_f (
        .aclk(clk), .aresetn(aresetn), .srst(srst), .en(en), .req(req), .done(done),
        .grant(grant_f), .grant_id(id_f), .busy(busy_f), .aged(aged_f)
    );

    axicb_prio_arbiter #(.REQ_NB(4), .PRIO_NB(4), .REQ_PRIORITY(8'hC0), .AGE_MAX(0)) dut_s (
        .aclk(clk), .aresetn(aresetn), .srst(srst), .en(en), .req(req), .done(done),
        .grant(grant_s), .grant_id(id_s), .busy(busy_s), .aged(aged_s)
    );

    axicb_prio_arbiter #(.REQ_NB(4), .PRIO_NB(4), .REQ_PRIORITY(8'hC0), .AGE_MAX(3)) dut_a (
        .aclk(clk), .aresetn(aresetn), .srst(srst), .en(en), .req(req), .done(done),
        .grant(grant_a), .grant_id(id_a), .busy(busy_a), .aged(aged_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_reset();
        en   = 1'b0;
        req  = '0;
        done = 1'b0;
        srst = 1'b1;
        step();
        srst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] exp_ga [5];
        logic [N-1:0] exp_aa [5];

        // Fair instance: rotation, hold, abort, idle done, en gating, simultaneous done+req
        tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
        tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
        tbl[5]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[6]  = '{1'b1, 4'b1110, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[7]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[8]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[9]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[11] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        tbl[12] = '{1'b0, 4'b0110, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[13] = '{1'b1, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[14] = '{1'b1, 4'b0110, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[15] = '{1'b1, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[16] = '{1'b1, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[17] = '{1'b1, 4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1};
        tbl[18] = '{1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
        tbl[19] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
        tbl[20] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1};
        tbl[21] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0};

        exp_ga = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
        exp_aa = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};

        aresetn = 1'b0;
        srst    = 1'b0;
        en      = 1'b0;
        req     = '0;
        done    = 1'b0;
        #12;
        check("reset grant", 32'(grant_f), 32'h0);
        check("reset grant_id", 32'(id_f), 32'h0);
        check("reset busy", 32'(busy_f), 32'h0);
        check("reset aged", 32'(aged_a), 32'h0);
        @(negedge clk);
        aresetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            en   = tbl[i].en;
            req  = tbl[i].req;
            done = tbl[i].done;
            step();
            check($sformatf("tbl%0d grant", i), 32'(grant_f), 32'(tbl[i].grant));
            check($sformatf("tbl%0d busy", i), 32'(busy_f), 32'(tbl[i].busy));
            if (tbl[i].busy) begin
                check($sformatf("tbl%0d grant_id", i), 32'(id_f), 32'(tbl[i].id));
            end
        end

        // Strict priority and aging promotion
        sync_reset();
        check("srst busy_s", 32'(busy_s), 32'h0);
        check("srst busy_a", 32'(busy_a), 32'h0);
        en  = 1'b1;
        req = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            done = (k >= 1 && k <= 3);
            step();
            check($sformatf("strict%0d grant", k), 32'(grant_s), 32'h8);
            check($sformatf("aging%0d grant", k), 32'(grant_a), 32'(exp_ga[k]));
            check($sformatf("aging%0d aged", k), 32'(aged_a), 32'(exp_aa[k]));
        end
        for (int k = 0; k < 4; k++) begin
            done = 1'b1;
            step();
            check($sformatf("strict_rearb%0d grant", k), 32'(grant_s), 32'h8);
            check($sformatf("strict_rearb%0d aged", k), 32'(aged_s), 32'h0);
        end

        // Ages freeze while en is low, grant stays held
        sync_reset();
        en   = 1'b1;
        req  = 4'b1001;
        done = 1'b0;
        step();
        step();
        check("freeze pre aged", 32'(aged_a), 32'h0);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("freeze%0d aged", k), 32'(aged_a), 32'h0);
            check($sformatf("freeze%0d grant", k), 32'(grant_a), 32'h8);
        end
        en = 1'b1;
        step();
        check("freeze resume aged", 32'(aged_a), 32'h1);

        // Hold under toggling requests, then abort hands over with no bubble
        sync_reset();
        en  = 1'b1;
        req = 4'b0010;
        step();
        check("hold first grant", 32'(grant_f), 32'h2);
        check("hold first id", 32'(id_f), 32'h1);
        for (int k = 0; k < 10; k++) begin
            req = (k % 2 == 1) ? 4'b1111 : 4'b0110;
            step();
            check($sformatf("hold%0d grant", k), 32'(grant_f), 32'h2);
        end
        req = 4'b1101;
        step();
        check("abort grant", 32'(grant_f), 32'h4);
        check("abort id", 32'(id_f), 32'h2);
        check("abort busy", 32'(busy_f), 32'h1);

        // Async reset mid-BUSY, pointer restart, then srst racing done
        req = 4'b1111;
        #3;
        aresetn = 1'b0;
        #1;
        check("async grant", 32'(grant_f), 32'h0);
        check("async busy_f", 32'(busy_f), 32'h0);
        check("async busy_s", 32'(busy_s), 32'h0);
        step();
        check("async held busy", 32'(busy_f), 32'h0);
        @(negedge clk);
        aresetn = 1'b1;
        en   = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
        step();
        check("post reset grant", 32'(grant_f), 32'h1);
        check("post reset id", 32'(id_f), 32'h0);
        done = 1'b1;
        step();
        check("post reset next", 32'(grant_f), 32'h2);
        srst = 1'b1;
        done = 1'b1;
        step();
        check("srst vs done busy", 32'(busy_f), 32'h0);
        check("srst vs done grant", 32'(grant_f), 32'h0);
        srst = 1'b0;
        done = 1'b0;
        step();
        check("post srst grant", 32'(grant_f), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
